reg_bank: RTL
=============

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001: Parameter NB_SEL, default 2, SHALL be the address width; the bank SHALL hold 2 ** NB_SEL registers.
REQ-002: Parameter WIDTH, default 8, SHALL be the data width of every register and data port.
REQ-003: Parameter ZERO_REG, default 0, SHALL hardwire register 0 to all-zeros when 1.
REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006: we  input  1  SHALL be the write enable.
REQ-007: waddr  input  NB_SEL  SHALL be the write register index.
REQ-008: wdata  input  WIDTH  SHALL be the write data.
REQ-009: raddr_a  input  NB_SEL  SHALL be the read port A register index.
REQ-010: raddr_b  input  NB_SEL  SHALL be the read port B register index.
REQ-011: rdata_a  output  WIDTH  SHALL be the read port A data.
REQ-012: rdata_b  output  WIDTH  SHALL be the read port B data.
REQ-013: wr_count  output  NB_SEL+2  SHALL count accepted writes, saturating.

Function
REQ-014: Each register SHALL be a WIDTH-bit edge-triggered register updated only on the rising edge of clk.
REQ-015: When we=1 and rst=0, the register at waddr SHALL load wdata at the next rising edge; all other registers SHALL hold.
REQ-016: When we=0, all registers SHALL hold.
REQ-017: Write select SHALL be a full NB_SEL-to-2**NB_SEL one-hot decode of waddr gated by we.
REQ-018: rdata_a and rdata_b SHALL be combinational selections of register raddr_a and raddr_b respectively, using one 2**NB_SEL-input mux per bit per port, with zero clock latency.
REQ-019: Both read ports SHALL be independent; raddr_a=raddr_b SHALL return identical data on both.
REQ-020: A read of the address being written in the same cycle SHALL return the old value until after the edge; the bank SHALL NOT bypass wdata.
REQ-021: With ZERO_REG=1, writes to address 0 SHALL be ignored, register 0 SHALL read as 0, and wr_count SHALL NOT increment for them.
REQ-022: wr_count SHALL increment by 1 on each rising edge with an accepted write and SHALL saturate at 2**(NB_SEL+2)-1 without wrap-around.
REQ-023: X-free: all outputs SHALL be defined after the first reset edge regardless of input history.

Reset
REQ-024: On a rising edge with rst=1, every register and wr_count SHALL become 0.
REQ-025: rst SHALL take priority over we in the same cycle; the write SHALL be discarded.
REQ-026: Reset asserted between writes SHALL clear all previously written data; no state SHALL survive.
REQ-027: Before the first reset edge, output values SHALL be unspecified; benches SHALL NOT check them.

Verification
REQ-028: Reset, then read all addresses on both ports -> every rdata is 0 and wr_count=0.
REQ-029: Defaults. Write 0xA5 to addr 2, 0x3C to addr 1, then raddr_a=2, raddr_b=1 -> rdata_a=0xA5, rdata_b=0x3C, wr_count=2.
REQ-030: we=1, waddr=3, wdata=0x77, raddr_a=3 in the same cycle as the edge -> rdata_a shows the old value before the edge and 0x77 after it.
REQ-031: rst=1 and we=1, waddr=0, wdata=0xFF in the same cycle -> after the edge, register 0 is 0 and wr_count=0.
REQ-032: ZERO_REG=1, write 0x11 to addr 0 -> rdata_a reads 0 and wr_count is unchanged; write 0x22 to addr 1 -> reads 0x22.
REQ-033: Issue 20 consecutive writes with NB_SEL=2 -> wr_count saturates at 15 and holds.

Source files
------------

// File: rtl/reg_bank.sv
// Register bank, one write port and two independent combinational read ports; reads have zero latency, writes land on the next edge.
// There is no backpressure: every write with we=1 is accepted, except writes to register 0 when ZERO_REG=1.
module reg_bank #(
   parameter int NB_SEL   = 2,
   parameter int WIDTH    = 8,
   parameter int ZERO_REG = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [NB_SEL-1:0]   waddr,
   input  logic [WIDTH-1:0]    wdata,
   input  logic [NB_SEL-1:0]   raddr_a,
   input  logic [NB_SEL-1:0]   raddr_b,
   output logic [WIDTH-1:0]    rdata_a,
   output logic [WIDTH-1:0]    rdata_b,
   output logic [NB_SEL+1:0]   wr_count
);

   localparam int NREG = 2 ** NB_SEL;
   localparam int CW   = NB_SEL + 2;

   logic [NREG-1:0]  wsel;
   logic [WIDTH-1:0] regs [NREG];
   logic             accepted;

   // With ZERO_REG set, register 0 is never selected, so it keeps its reset value of zero.
   always_comb begin
      wsel = '0;
      if (we) begin
         wsel[waddr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         wsel[0] = 1'b0;
      end
   end

   assign accepted = |wsel;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (wsel[i]) begin
               regs[i] <= wdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count <= '0;
      end else if (accepted && (wr_count != {CW{1'b1}})) begin
         wr_count <= wr_count + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule
